// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and twiddle ROM layout helper for the
// radix-2 FFT twiddle/address sequencer.
package fft_pkg;

    localparam int FFT_SIZE       = 128;
    localparam int LOG2_N         = $clog2(FFT_SIZE);
    localparam int TWID_ADDR_SIZE = $clog2(FFT_SIZE - 1);
    localparam int STAGE_W        = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_t;

    // Stage s twiddles start at 2^s-1 in the ROM (1+2+4+... packing).
    function automatic int unsigned twid_base(input int unsigned s);
        return (32'd1 << s) - 32'd1;
    endfunction

endpackage

// File: rtl/fft_bfly_addr_calc.sv
// Combinational butterfly address maths: (stage, j) -> data addresses and
// twiddle ROM address.
module fft_bfly_addr_calc #(
    parameter int FFT_SIZE       = fft_pkg::FFT_SIZE,
    parameter int LOG2_N         = $clog2(FFT_SIZE),
    parameter int STAGE_W        = (LOG2_N > 1) ? $clog2(LOG2_N) : 1,
    parameter int TWID_ADDR_SIZE = $clog2(FFT_SIZE - 1)
) (
    input  logic [STAGE_W-1:0]        stage_i,
    input  logic [LOG2_N-2:0]         j_i,
    output logic [LOG2_N-1:0]         addr_a_o,
    output logic [LOG2_N-1:0]         addr_b_o,
    output logic [TWID_ADDR_SIZE-1:0] rom_addr_o
);
    import fft_pkg::*;

    logic [LOG2_N-1:0] j_ext;
    logic [LOG2_N-1:0] span;
    logic [LOG2_N-1:0] k;
    logic [LOG2_N-1:0] grp;

    // Split j into group and in-group offset; the group index is re-spread
    // with a zero at bit s so addr_b is addr_a with that bit set.
    always_comb begin
        j_ext      = {1'b0, j_i};
        span       = LOG2_N'(1) << stage_i;
        k          = j_ext & (span - LOG2_N'(1));
        grp        = j_ext >> stage_i;
        addr_a_o   = ((grp << stage_i) << 1) + k;
        addr_b_o   = addr_a_o + span;
        rom_addr_o = TWID_ADDR_SIZE'(twid_base(32'(stage_i)) + 32'(k));
    end

endmodule

// File: rtl/fft_twiddle_addr_gen.sv
// Radix-2 in-place FFT butterfly sequencer. Walks stage s / butterfly j,
// presenting registered data addresses and twiddle ROM address with a
// valid/ready handshake. Optional inter-stage bubbles via TWID_STAGE_GAP_EN.
module fft_twiddle_addr_gen #(
    parameter int FFT_SIZE       = fft_pkg::FFT_SIZE,
    parameter int LOG2_N         = $clog2(FFT_SIZE),
    parameter int TWID_ADDR_SIZE = $clog2(FFT_SIZE - 1)
`ifdef TWID_STAGE_GAP_EN
    ,
    parameter int STAGE_GAP      = 4
`endif
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_start,
    input  logic                                         i_ready,
    output logic                                         o_valid,
    output logic                                         o_rom_en,
    output logic [TWID_ADDR_SIZE-1:0]                    o_rom_addr,
    output logic [LOG2_N-1:0]                            o_addr_a,
    output logic [LOG2_N-1:0]                            o_addr_b,
    output logic [((LOG2_N > 1) ? $clog2(LOG2_N) : 1)-1:0] o_stage,
    output logic                                         o_last,
    output logic                                         o_busy,
    output logic                                         o_done
);
    import fft_pkg::*;

    localparam int STAGE_W = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
    localparam int JW      = LOG2_N - 1;
    localparam logic [JW-1:0]      J_LAST = JW'(FFT_SIZE / 2 - 1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2_N - 1);

    fsm_state_t state_q, state_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [JW-1:0]      j_q, j_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, done_q;
    logic [LOG2_N-1:0]  addr_a_q, addr_b_q;
    logic [TWID_ADDR_SIZE-1:0] rom_addr_q;
    logic [STAGE_W-1:0] stage_q;

    logic [LOG2_N-1:0]         calc_a, calc_b;
    logic [TWID_ADDR_SIZE-1:0] calc_rom;
    logic                      xfer;

`ifdef TWID_STAGE_GAP_EN
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    // Addresses are computed from the next-state counters so every output
    // can be registered and still line up with o_valid.
    fft_bfly_addr_calc #(
        .FFT_SIZE       (FFT_SIZE),
        .LOG2_N         (LOG2_N),
        .STAGE_W        (STAGE_W),
        .TWID_ADDR_SIZE (TWID_ADDR_SIZE)
    ) u_calc (
        .stage_i    (s_d),
        .j_i        (j_d),
        .addr_a_o   (calc_a),
        .addr_b_o   (calc_b),
        .rom_addr_o (calc_rom)
    );

    // Next-state: counters advance only on a completed handshake.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        valid_d = valid_q;
`ifdef TWID_STAGE_GAP_EN
        gap_d   = gap_q;
`endif
        xfer    = valid_q && i_ready;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                    valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            s_d     = '0;
                        end else begin
                            s_d = s_q + 1'b1;
`ifdef TWID_STAGE_GAP_EN
                            state_d = ST_GAP;
                            valid_d = 1'b0;
                            gap_d   = '0;
`endif
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
`ifdef TWID_STAGE_GAP_EN
            ST_GAP: begin
                // Drain bubbles so the next stage never reads a stale word.
                if (gap_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        last_d = valid_d && (s_d == S_LAST) && (j_d == J_LAST);
    end

    // State and registered outputs; outputs read zero whenever not valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            rom_addr_q <= '0;
            stage_q    <= '0;
`ifdef TWID_STAGE_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            addr_a_q   <= valid_d ? calc_a : '0;
            addr_b_q   <= valid_d ? calc_b : '0;
            rom_addr_q <= valid_d ? calc_rom : '0;
            stage_q    <= valid_d ? s_d : '0;
`ifdef TWID_STAGE_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign o_valid    = valid_q;
    assign o_rom_en   = valid_q;
    assign o_rom_addr = rom_addr_q;
    assign o_addr_a   = addr_a_q;
    assign o_addr_b   = addr_b_q;
    assign o_stage    = stage_q;
    assign o_last     = last_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Self-checking bench for fft_twiddle_addr_gen against an arithmetic model
// of the butterfly schedule. Honours TWID_STAGE_GAP_EN when defined.
module tb_fft_twiddle_addr_gen;

    localparam int N      = fft_pkg::FFT_SIZE;
    localparam int LN     = fft_pkg::LOG2_N;
    localparam int TW     = fft_pkg::TWID_ADDR_SIZE;
    localparam int SW     = fft_pkg::STAGE_W;
    localparam int NX     = LN * N / 2;
`ifdef TWID_STAGE_GAP_EN
    localparam int GAP    = 4;
`else
    localparam int GAP    = 0;
`endif
    localparam int BUBBLES = (LN - 1) * GAP;
    localparam int BUDGET  = 4000;

    logic          clk = 1'b0;
    logic          rst, start, ready;
    logic          valid, rom_en, last, busy, done;
    logic [TW-1:0] rom_addr;
    logic [LN-1:0] addr_a, addr_b;
    logic [SW-1:0] stage;

    int n_tests = 0;
    int n_fail  = 0;

    int ea [NX];
    int eb [NX];
    int er [NX];
    int es [NX];

    always #5 clk = ~clk;

    fft_twiddle_addr_gen dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_ready    (ready),
        .o_valid    (valid),
        .o_rom_en   (rom_en),
        .o_rom_addr (rom_addr),
        .o_addr_a   (addr_a),
        .o_addr_b   (addr_b),
        .o_stage    (stage),
        .o_last     (last),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Schedule straight from the butterfly definition: stage s pairs
    // elements span apart inside blocks of 2*span.
    task automatic build_model();
        int i = 0;
        for (int s = 0; s < LN; s++) begin
            for (int j = 0; j < N / 2; j++) begin
                int span = 2 ** s;
                ea[i] = (j / span) * 2 * span + (j % span);
                eb[i] = ea[i] + span;
                er[i] = (span - 1) + (j % span);
                es[i] = s;
                i++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_outs"}, {rom_en, last, rom_addr, addr_a, addr_b, stage}, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready dropped 3 cycles at
    // stage 1 j 2. glitch pulses i_start mid-run.
    task automatic run_xform(input int mode, input bit glitch);
        int  idx = 0, cyc = 0, mid_inv = 0, drop = 0, dones = 0;
        bit  r, xf;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("first_valid", valid, 1);
        while (idx < NX && cyc < BUDGET) begin
            if (valid) begin
                chk("addr_a", addr_a, ea[idx]);
                chk("addr_b", addr_b, eb[idx]);
                chk("rom_addr", rom_addr, er[idx]);
                chk("stage", stage, es[idx]);
                chk("last", last, (idx == NX - 1));
                chk("rom_en", rom_en, 1);
                if (idx == 0)
                    chk("first_bfly", {addr_a, addr_b, rom_addr}, {7'd0, 7'd1, 7'd0});
                if (idx == 2 * 64 + 5)
                    chk("s2_j5", {addr_a, addr_b, rom_addr}, {7'd9, 7'd13, 7'd4});
                if (idx == NX - 1)
                    chk("s6_j63", {addr_a, addr_b, rom_addr}, {7'd63, 7'd127, 7'd126});
                if (mode == 2 && idx == 66)
                    chk("bp_hold", {addr_a, addr_b, rom_addr}, {7'd4, 7'd6, 7'd1});
                if (mode == 2 && idx == 67)
                    chk("bp_next", {addr_a, addr_b, rom_addr}, {7'd5, 7'd7, 7'd2});
            end else begin
                mid_inv++;
            end
            chk("busy_run", busy, 1);
            if (done) dones++;
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                default: begin
                    r = 1'b1;
                    if (idx == 66 && drop < 3) begin
                        r = 1'b0;
                        drop++;
                    end
                end
            endcase
            ready = r;
            start = glitch && (cyc == 200 || cyc == 201);
            xf = valid && r;
            tick();
            cyc++;
            if (xf) idx++;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("xfers", idx, NX);
        chk("early_done", dones, 0);
        chk("done_pulse", done, 1);
        chk("valid_after", valid, 0);
        chk("busy_done", busy, 1);
        if (mode == 0) chk("cycles", cyc, NX + BUBBLES + 1);
        chk("bubbles", mid_inv, BUBBLES);
        if (mode == 2) chk("bp_drops", drop, 3);
        tick();
        chk_idle("post_done");
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || valid) dones++;
        end
        chk("no_restart", dones, 0);
    endtask

    task automatic run_reset_mid();
        int idx = 0, cyc = 0, dones = 0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (idx < 3 * 64 + 10 && cyc < BUDGET) begin
            if (valid) idx++;
            tick();
            cyc++;
        end
        chk("rst_stage", stage, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("mid_rst");
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || valid || busy) dones++;
        end
        chk("rst_quiet", dones, 0);
    endtask

    initial begin
        build_model();
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("idle");
        run_xform(0, 1'b0);
        run_xform(2, 1'b0);
        run_xform(1, 1'b0);
        run_xform(0, 1'b1);
        run_reset_mid();
        run_xform(1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
